// File: rtl/videomem3.sv
// videomem3: character-cell video memory. It has a cursor-driven write port with
// control codes, a hardware screen-clear FSM, and a two-stage pixel read pipeline
// that feeds an external font ROM and produces RGB levels with per-cell inverse video.
module videomem3 #(
  parameter int DISP_WIDTH_PX = 640,
  parameter int DISP_HEIGHT_PX = 480,
  parameter int CH_WIDTH = 4,
  parameter int CH_HEIGHT = 8,
  parameter int COLOR_BITS = 6,
  parameter logic [COLOR_BITS-1:0] FG_LEVEL = 6'h3F,
  parameter logic [COLOR_BITS-1:0] BG_LEVEL = 6'h00
) (
  input  logic                             vm_clk,
  input  logic                             vm_rst,
  input  logic [7:0]                       vm_ch_in,
  input  logic                             vm_ch_valid,
  output logic                             vm_ch_ready,
  input  logic                             vm_clear,
  output logic [7:0]                       vm_cur_col,
  output logic [5:0]                       vm_cur_row,
  input  logic [9:0]                       vm_px,
  input  logic [9:0]                       vm_py,
  output logic [7+$clog2(CH_HEIGHT)-1:0]   vm_font_addr,
  input  logic [CH_WIDTH-1:0]              vm_font_row,
  output logic [COLOR_BITS-1:0]            vm_r,
  output logic [COLOR_BITS-1:0]            vm_g,
  output logic [COLOR_BITS-1:0]            vm_b
);

  localparam int CH_COLS = DISP_WIDTH_PX / CH_WIDTH;
  localparam int CH_ROWS = DISP_HEIGHT_PX / CH_HEIGHT;
  localparam int CH_SCREENSIZE = CH_COLS * CH_ROWS;
  localparam int ADDR_BITS = $clog2(CH_SCREENSIZE);
  localparam int COL_BITS = $clog2(CH_WIDTH);
  localparam int ROW_BITS = $clog2(CH_HEIGHT);
  localparam logic [ADDR_BITS-1:0] LAST_CELL = ADDR_BITS'(CH_SCREENSIZE - 1);
  localparam logic [7:0] LAST_COL = 8'(CH_COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(CH_ROWS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] clr_cnt, clr_cnt_next;
  logic [7:0]           col, col_next;
  logic [5:0]           row, row_next;
  logic                 accept;
  logic [ADDR_BITS-1:0] cur_cell;
  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic [7:0]           wdata;

  logic [7:0]           mem [0:CH_SCREENSIZE-1];

  logic                 in_area;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [7:0]           cell_q;
  logic [COL_BITS-1:0]  col_q;
  logic [ROW_BITS-1:0]  row_q;
  logic                 in_area_q;
  logic [COL_BITS-1:0]  pix_sel;
  logic                 lit;
  logic [COLOR_BITS-1:0] level;

  // Row advance with wrap to the top; there is no scrolling.
  function automatic logic [5:0] row_adv(input logic [5:0] r);
    return (r == LAST_ROW) ? 6'd0 : r + 6'd1;
  endfunction

  assign vm_ch_ready = (state == ST_IDLE) && !vm_clear;
  assign accept      = vm_ch_valid && vm_ch_ready;
  assign cur_cell    = ADDR_BITS'(int'(row) * CH_COLS + int'(col));
  assign vm_cur_col  = col;
  assign vm_cur_row  = row;

  // Next-state logic: clear sweep, control-code handling, and the single write port.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    col_next     = col;
    row_next     = row;
    we           = 1'b0;
    waddr        = clr_cnt;
    wdata        = 8'h20;
    case (state)
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = 8'h20;
        if (vm_clear) begin
          clr_cnt_next = '0;
          col_next     = 8'd0;
          row_next     = 6'd0;
        end else if (clr_cnt == LAST_CELL) begin
          state_next   = ST_IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt + ADDR_BITS'(1);
        end
      end
      ST_IDLE: begin
        if (vm_clear) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
          col_next     = 8'd0;
          row_next     = 6'd0;
        end else if (accept) begin
          case (vm_ch_in)
            8'h0A: begin
              col_next = 8'd0;
              row_next = row_adv(row);
            end
            8'h0D: begin
              col_next = 8'd0;
            end
            8'h08: begin
              if (col != 8'd0) begin
                col_next = col - 8'd1;
              end else begin
                col_next = col;
              end
            end
            default: begin
              we    = 1'b1;
              waddr = cur_cell;
              wdata = vm_ch_in;
              if (col < LAST_COL) begin
                col_next = col + 8'd1;
              end else begin
                col_next = 8'd0;
                row_next = row_adv(row);
              end
            end
          endcase
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next   = ST_CLEAR;
        clr_cnt_next = '0;
        col_next     = 8'd0;
        row_next     = 6'd0;
      end
    endcase
  end

  // FSM, clear counter and cursor registers.
  always_ff @(posedge vm_clk or posedge vm_rst) begin
    if (vm_rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      col     <= 8'd0;
      row     <= 6'd0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
      col     <= col_next;
      row     <= row_next;
    end
  end

  // Character memory write port (contents are blanked by the clear sweep, not by reset).
  always_ff @(posedge vm_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-area coordinates fall back to cell 0 so the read never leaves the array.
  assign in_area = (int'(vm_px) < DISP_WIDTH_PX) && (int'(vm_py) < DISP_HEIGHT_PX);
  assign rd_addr = in_area ? ADDR_BITS'(int'(vm_py >> ROW_BITS) * CH_COLS + int'(vm_px >> COL_BITS))
                           : '0;

  // Stage 1 memory read; a same-cycle write is not visible here (old data returned).
  always_ff @(posedge vm_clk) begin
    cell_q <= mem[rd_addr];
  end

  // Stage 1 pixel position within the cell and the visible-area flag.
  always_ff @(posedge vm_clk or posedge vm_rst) begin
    if (vm_rst) begin
      col_q     <= '0;
      row_q     <= '0;
      in_area_q <= 1'b0;
    end else begin
      col_q     <= vm_px[COL_BITS-1:0];
      row_q     <= vm_py[ROW_BITS-1:0];
      in_area_q <= in_area;
    end
  end

  assign vm_font_addr = {cell_q[6:0], row_q};
  assign pix_sel      = COL_BITS'(CH_WIDTH - 1) - col_q;

  // Stage 2 glyph bit selection with inverse video from code bit 7.
  always_comb begin
    lit   = vm_font_row[pix_sel] ^ cell_q[7];
    level = BG_LEVEL;
    if (!in_area_q) begin
      level = '0;
    end else if (lit) begin
      level = FG_LEVEL;
    end else begin
      level = BG_LEVEL;
    end
  end

  // Stage 2 registered colour outputs, all channels equal.
  always_ff @(posedge vm_clk or posedge vm_rst) begin
    if (vm_rst) begin
      vm_r <= '0;
      vm_g <= '0;
      vm_b <= '0;
    end else begin
      vm_r <= level;
      vm_g <= level;
      vm_b <= level;
    end
  end

endmodule

// File: doc/videomem3.md
Name: videomem3

Overview:
- Parametrised successor to the character video memory.
- Holds one 8-bit code per character cell. A cursor-driven, handshaked write port handles control codes, auto-advance and wrap.
- Hardware clear FSM blanks the screen after reset or on command.
- Pixel read pipeline drives an external font ROM and produces RGB levels with per-cell inverse video, for the VGA timing block.

Parameters:
- DISP_WIDTH_PX, 640, visible width in pixels.
- DISP_HEIGHT_PX, 480, visible height in pixels.
- CH_WIDTH, 4, character width in pixels (power of two).
- CH_HEIGHT, 8, character height in pixels (power of two).
- COLOR_BITS, 6, bits per colour channel.
- FG_LEVEL, 6'h3F, channel level for lit glyph pixels.
- BG_LEVEL, 6'h00, channel level for unlit glyph pixels.
- Derived: CH_COLS = DISP_WIDTH_PX/CH_WIDTH (160); CH_ROWS = DISP_HEIGHT_PX/CH_HEIGHT (60); CH_SCREENSIZE = CH_COLS*CH_ROWS (9600).

Ports:
- vm_clk  in  1  single clock for write, clear and read pipeline.
- vm_rst  in  1  asynchronous, active-high reset.
- vm_ch_in  in  8  character code to write.
- vm_ch_valid  in  1  write request.
- vm_ch_ready  out  1  block can accept a character this cycle.
- vm_clear  in  1  single-cycle pulse: clear screen, home cursor.
- vm_cur_col  out  8  cursor column, 0..CH_COLS-1.
- vm_cur_row  out  6  cursor row, 0..CH_ROWS-1.
- vm_px, vm_py  in  10 each  pixel coordinate being scanned.
- vm_font_addr  out  7+log2(CH_HEIGHT)  {code[6:0], glyph row} to external combinational font ROM.
- vm_font_row  in  CH_WIDTH  glyph row bits from ROM, same cycle; MSB = leftmost pixel.
- vm_r, vm_g, vm_b  out  COLOR_BITS each  pixel colour.

Behaviour:
- Reset (asynchronous):
  - cursor = (0,0); vm_r/g/b = 0; pipeline valid flags = 0.
  - FSM enters CLEAR with cell counter = 0; vm_ch_ready = 0.
  - Memory contents are not reset directly; the CLEAR pass overwrites them.
- FSM state IDLE:
  - vm_ch_ready = !vm_clear.
  - Write accepted when vm_ch_valid && vm_ch_ready.
  - vm_clear = 1: go to CLEAR with counter = 0 and home the cursor. A simultaneous character is not accepted.
- FSM state CLEAR:
  - Writes 8'h20 to cell[counter] each cycle, then counter+1. Takes CH_SCREENSIZE cycles.
  - After writing cell CH_SCREENSIZE-1, go to IDLE; ready is high on the next cycle.
  - vm_clear during CLEAR restarts the counter at 0.
  - vm_ch_ready = 0 throughout.
- Accepted codes. Cell index = row*CH_COLS + col.
  - 8'h0A: col = 0, row advances.
  - 8'h0D: col = 0, row unchanged.
  - 8'h08: col = col-1 if col > 0, else no change. No memory write.
  - Any other code: stored at the cursor cell. If col < CH_COLS-1, col+1; else col = 0 and row advances.
  - Row advance: row+1; from CH_ROWS-1, row wraps to 0. No scrolling.
  - One character per cycle at full throughput. Cursor outputs update the cycle after acceptance.
- Read pipeline (always running, including during CLEAR):
  - Stage 1 (registered): cell_q = mem[(py/CH_HEIGHT)*CH_COLS + px/CH_WIDTH]. Also register col_q = px%CH_WIDTH, row_q = py%CH_HEIGHT, and in_area_q = (px < DISP_WIDTH_PX && py < DISP_HEIGHT_PX).
  - Stage 2: vm_font_addr = {cell_q[6:0], row_q} (combinational). lit = vm_font_row[CH_WIDTH-1-col_q] ^ cell_q[7]. Register vm_r/g/b = FG_LEVEL if lit else BG_LEVEL, all channels equal.
  - Forced output: if !in_area_q, all channels = 0.
  - Latency: exactly 2 vm_clk edges from vm_px/vm_py to vm_r/g/b.
  - Out-of-area coordinates must not index past the memory; the address is don't-care but bounded.
- Read/write collision: a read of a cell written in the same cycle returns the old value.

Test Plan:
- Reset, then idle: vm_ch_ready = 0 for 9600 cycles, then 1. A pixel read at every cell returns font code 0x20 in vm_font_addr. Cursor = (0,0).
- Write 'H','i',0x0A,'X': cells 0 = 0x48, 1 = 0x69, 160 = 0x58. Final cursor (1,1).
- 160 printable chars on row 59: the 160th lands at cell 9599. Cursor wraps to (0,0). Next char overwrites cell 0.
- Backspace at col 0 leaves the cursor unchanged. 0x0D from col 37 gives col 0, row unchanged.
- Font stub returns 4'b1000 for code 0x41; cell 0 = 0x41. Drive px = 0,1 at py = 0: two cycles later r/g/b = 3F then 00. With cell = 0xC1, output is 00 then 3F. px = 640 gives output 0.
- vm_clear asserted with vm_ch_valid high mid-stream: char not accepted, cursor = (0,0), ready low 9600 cycles. Second vm_clear at cycle 100 extends ready-low to 9700 cycles total.
